// File: rtl/wires_2b_deser_4x2b_pkg.sv
//==============================================================================
// Module  : wires_2b_deser_4x2b_pkg
// Brief   : Shared types and constants for the 4x2b lane serializer/deserializer
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package wires_2b_deser_4x2b_pkg;

  localparam int NLANES = 4;
  localparam int CNT_W  = $clog2(NLANES);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wires_beat_counter.sv
//==============================================================================
// Module  : wires_beat_counter
// Brief   : Beat counter with increment, clear and wrap flag (shared by ser/deser)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module wires_beat_counter
  import wires_2b_deser_4x2b_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority so a wrapping increment lands on zero explicitly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign wrap  = inc && (r_count == {WIDTH{1'b1}});

endmodule

`default_nettype wire

// File: rtl/wires_2b_deser_4x2b.sv
//==============================================================================
// Module  : wires_2b_deser_4x2b
// Brief   : Rebuilds four 2b lanes from a serial 2b beat stream, lane 0 first
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module wires_2b_deser_4x2b
  import wires_2b_deser_4x2b_pkg::*;
#(
  parameter int p_nbits = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_data,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   w_count;
  logic               w_wrap;
  logic               w_accept;
  logic [p_nbits-1:0] r_lane [NLANES];

  assign w_accept = in_val && in_rdy;

  wires_beat_counter #(
    .WIDTH (CNT_W)
  ) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_accept),
    .clear (w_accept && w_wrap),
    .count (w_count),
    .wrap  (w_wrap)
  );

  // While FULL the count sits at 0, so a same-cycle beat lands in lane 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NLANES; i++) begin
        r_lane[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_count == CNT_W'(i)) begin
          r_lane[i] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      COLLECT: if (w_accept && w_wrap) w_next_state = FULL;
      FULL:    if (out_rdy)            w_next_state = COLLECT;
      default:                         w_next_state = COLLECT;
    endcase
  end

  always_comb begin
    in_rdy  = 1'b1;
    out_val = 1'b0;
    unique case (r_state)
      COLLECT: begin
        in_rdy  = 1'b1;
        out_val = 1'b0;
      end
      FULL: begin
        in_rdy  = out_rdy;
        out_val = 1'b1;
      end
      default: begin
        in_rdy  = 1'b1;
        out_val = 1'b0;
      end
    endcase
  end

  assign out0 = r_lane[0];
  assign out1 = r_lane[1];
  assign out2 = r_lane[2];
  assign out3 = r_lane[3];

endmodule

`default_nettype wire

// File: tb/tb_wires_2b_deser_4x2b.sv
//==============================================================================
// Module  : tb_wires_2b_deser_4x2b
// Brief   : Scoreboard bench for the 4x2b deserializer against a queue model
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wires_2b_deser_4x2b;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [1:0] in_data;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] out0, out1, out2, out3;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: beats of the word being built, plus the word on offer
  logic [1:0] beats [$];
  logic [7:0] sb    [$];
  logic       m_pend;
  logic [7:0] m_word;

  wires_2b_deser_4x2b #(
    .p_nbits (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model
  task automatic step(input logic v, input logic [1:0] d, input logic r);
    logic exp_rdy, xfer, acc;
    @(negedge clk);
    in_val  = v;
    in_data = d;
    out_rdy = r;
    #1;
    exp_rdy = !m_pend || r;
    chk("in_rdy", {7'd0, in_rdy}, {7'd0, exp_rdy});
    chk("out_val", {7'd0, out_val}, {7'd0, m_pend});
    if (m_pend) chk("lanes_held", {out3, out2, out1, out0}, m_word);
    xfer = m_pend && r;
    acc  = v && exp_rdy;
    if (xfer) m_pend = 1'b0;
    if (acc) begin
      beats.push_back(d);
      if (beats.size() == 4) begin
        m_word = {beats[3], beats[2], beats[1], beats[0]};
        sb.push_back(m_word);
        beats.delete();
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_val  = 1'b0;
    out_rdy = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("rst_out_val", {7'd0, out_val}, 8'd0);
    chk("rst_lanes", {out3, out2, out1, out0}, 8'd0);
    beats.delete();
    sb.delete();
    m_pend = 1'b0;
    m_word = 8'd0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every word handshake
  initial begin
    logic [7:0] exp_w;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_val && out_rdy) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL word_unexpected: got %02h, expected no word", {out3, out2, out1, out0});
        end else begin
          exp_w = sb.pop_front();
          chk("word", {out3, out2, out1, out0}, exp_w);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    in_data = 2'b00;
    out_rdy = 1'b0;
    m_pend  = 1'b0;
    m_word  = 8'd0;
    #12;
    do_reset();

    // Basic word 01,10,11,00 with ready downstream
    step(1, 2'b01, 1); step(1, 2'b10, 1); step(1, 2'b11, 1); step(1, 2'b00, 1);
    step(0, 2'b00, 1); step(0, 2'b00, 1);

    // Backpressure for 5 cycles with a beat waiting, then release
    step(1, 2'b00, 1); step(1, 2'b01, 1); step(1, 2'b10, 1); step(1, 2'b11, 1);
    for (int i = 0; i < 5; i++) step(1, 2'b11, 0);
    step(1, 2'b11, 1); step(1, 2'b00, 1); step(1, 2'b01, 1); step(1, 2'b10, 1);
    step(0, 2'b00, 1);

    // Continuous stream: two words without bubbles
    step(1, 2'd0, 1); step(1, 2'd1, 1); step(1, 2'd2, 1); step(1, 2'd3, 1);
    step(1, 2'd3, 1); step(1, 2'd2, 1); step(1, 2'd1, 1); step(1, 2'd0, 1);
    step(0, 2'd0, 1); step(0, 2'd0, 1);

    // Partial word held across an idle gap
    step(1, 2'b10, 1); step(1, 2'b01, 1);
    for (int i = 0; i < 10; i++) step(0, 2'($urandom_range(0, 3)), 1);
    step(1, 2'b11, 1); step(1, 2'b10, 1);
    step(0, 2'b00, 1); step(0, 2'b00, 1);

    // Reset mid-word, then a fresh word
    step(1, 2'b11, 1); step(1, 2'b11, 1); step(1, 2'b11, 1);
    do_reset();
    step(1, 2'b01, 0); step(1, 2'b00, 0); step(1, 2'b11, 0); step(1, 2'b10, 0);
    step(0, 2'b00, 0);
    // Reset while FULL
    do_reset();
    step(1, 2'b10, 1); step(1, 2'b11, 1); step(1, 2'b00, 1); step(1, 2'b01, 1);
    step(0, 2'b00, 1);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 4; i++) step(0, 2'b00, 1);

    @(negedge clk);
    #3;
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
